rename_stage: RTL and testbench
===============================

Name: rename_stage

Overview:
- Two-wide register-rename stage between the decode/rename pipeline register and dispatch.
- Maps 5-bit architectural source and destination registers to 6-bit physical registers (64 physical, 32 architectural).
- Uses a speculative RAT, a committed RAT and a circular free list. Resolves intra-group dependencies.
- Returns freed physical registers at commit and restores state on flush.

Parameters:
- ARCH_W, 5, architectural register index width (32 registers).
- PHYS_W, 6, physical register index width (64 registers).
- FL_DEPTH, 32, free-list entries (equals 2^PHYS_W - 2^ARCH_W).

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- in_valid_1/_2  in  1  slot valid from the decode/rename register. in_valid_2 is only ever asserted with in_valid_1.
- rd_write_1/_2  in  1  slot writes a destination register.
- rs1_1/_2, rs2_1/_2, rd_1/_2  in  5  architectural sources and destination.
- in_ready  out  1  group accepted this cycle; drives the decode/rename register enable.
- out_ready  in  1  dispatch can take the output group.
- out_valid_1/_2  out  1  renamed slot valid.
- prs1_1/_2, prs2_1/_2  out  6  physical sources.
- prd_1/_2  out  6  physical destination; 0 when no allocation.
- old_prd_1/_2  out  6  previous mapping of rd, freed at commit; 0 when no allocation.
- commit_valid_1/_2  in  1  ROB retires slot; slot 1 is older.
- commit_rd_write_1/_2  in  1  retiring instruction allocated a register.
- commit_ard_1/_2  in  5  its architectural rd.
- commit_prd_1/_2, commit_old_prd_1/_2  in  6  its new and old physical rd.
- flush  in  1  mispredict/exception recovery, single-cycle pulse.

Behaviour:

Reset (asynchronous, reset==0):
- Speculative RAT[i]=i and committed RAT[i]=i.
- Free list entry k=32+k.
- spec_head=0, commit_head=0, tail=32. Pointers are 6-bit: 5-bit index plus wrap bit.
- All out_valid=0. All other outputs = 0.
- Reset mid-operation discards in-flight groups.

Allocation and stall:
- alloc_n = number of slots with in_valid & rd_write & rd!=0.
- free_cnt = tail - spec_head (0..32).
- in_ready = !flush & (!out_valid_1 | out_ready) & (free_cnt >= alloc_n).
- fire = in_valid_1 & in_ready.

On fire (outputs registered, 1-cycle latency):
- Sources read the speculative RAT as it stood before this group. x0 always maps to p0.
- Slot 2 bypass: if slot 1 allocates and rs1_2/rs2_2 == rd_1, then prs1_2/prs2_2 take slot 1's new prd.
- Slot 1 allocates from free list[spec_head]. Slot 2 allocates from the next entry, or from spec_head if slot 1 does not allocate.
- old_prd = RAT[rd]. If both slots write the same rd, old_prd_2 = prd_1.
- RAT is written with the new prd. If both slots write the same rd, slot 2's write wins.
- spec_head advances by alloc_n.
- A rd_write with rd==0 gives prd=old_prd=0, no allocation, no RAT write.

Output hold:
- If out_valid is set and out_ready=0, all outputs hold.
- If out_ready=1 with no fire, out_valid clears.

Commit (every cycle, independent of fire):
- For each slot with commit_valid & commit_rd_write & ard!=0, in order slot 1 then slot 2:
  - committed RAT[ard] = prd; slot 2 wins on an equal ard.
  - free list[tail] = old_prd; tail+1.
  - commit_head+1.

Flush (highest priority):
- Same-cycle commits apply first.
- Speculative RAT copies the post-commit committed RAT.
- spec_head = post-commit commit_head.
- out_valid cleared; in_ready=0; any input group is dropped.
- Next cycle, free_cnt = tail - commit_head.

Wrap-around and capacity:
- All pointers wrap modulo 64; the index is the low 5 bits.
- Live entries between commit_head and tail never exceed 32, so tail cannot overwrite unretired allocations.

Test Plan:
- Reset, then slot1 rd=5 rs1=5 and slot2 rd=6 rs1=5 rs2=0 -> next cycle: prd_1=32, old_prd_1=5, prs1_1=5; prd_2=33, prs1_2=32 (bypass), prs2_2=0, old_prd_2=6.
- Both slots rd=7 -> prd_1=32, prd_2=33, old_prd_1=7, old_prd_2=32; a later read of rs1=7 gives 33.
- 16 groups of two allocations with no commits -> free_cnt=0; next allocating group sees in_ready=0; a group with rd=0 or rd_write=0 is still accepted; one commit returning p5 lets a single-allocation group through with prd=5.
- out_ready=0 for 3 cycles with a pending group -> outputs stable, in_ready=0, RAT and spec_head unchanged.
- Rename rd=3->32 and rd=4->33, commit only the first, then flush -> rs1=3 maps to 32, rs1=4 maps to 4; next allocation gets 33 again.
- Flush in the same cycle as commit_valid_1 (ard=9, prd=40) and a valid input group -> group dropped, speculative RAT[9]=40, out_valid=0.

Source files
------------

// File: rtl/rename_stage.sv
// Two-wide register rename stage: speculative/committed RATs, circular free list,
// intra-group bypass, commit-time register return and flush recovery.
module rename_stage #(
    parameter int ARCH_W   = 5,
    parameter int PHYS_W   = 6,
    parameter int FL_DEPTH = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid_1,
    input  logic              in_valid_2,
    input  logic              rd_write_1,
    input  logic              rd_write_2,
    input  logic [ARCH_W-1:0] rs1_1,
    input  logic [ARCH_W-1:0] rs1_2,
    input  logic [ARCH_W-1:0] rs2_1,
    input  logic [ARCH_W-1:0] rs2_2,
    input  logic [ARCH_W-1:0] rd_1,
    input  logic [ARCH_W-1:0] rd_2,
    output logic              in_ready,
    input  logic              out_ready,
    output logic              out_valid_1,
    output logic              out_valid_2,
    output logic [PHYS_W-1:0] prs1_1,
    output logic [PHYS_W-1:0] prs1_2,
    output logic [PHYS_W-1:0] prs2_1,
    output logic [PHYS_W-1:0] prs2_2,
    output logic [PHYS_W-1:0] prd_1,
    output logic [PHYS_W-1:0] prd_2,
    output logic [PHYS_W-1:0] old_prd_1,
    output logic [PHYS_W-1:0] old_prd_2,
    input  logic              commit_valid_1,
    input  logic              commit_valid_2,
    input  logic              commit_rd_write_1,
    input  logic              commit_rd_write_2,
    input  logic [ARCH_W-1:0] commit_ard_1,
    input  logic [ARCH_W-1:0] commit_ard_2,
    input  logic [PHYS_W-1:0] commit_prd_1,
    input  logic [PHYS_W-1:0] commit_prd_2,
    input  logic [PHYS_W-1:0] commit_old_prd_1,
    input  logic [PHYS_W-1:0] commit_old_prd_2,
    input  logic              flush
);
    localparam int IDX_W    = $clog2(FL_DEPTH);
    localparam int PTR_W    = IDX_W + 1;
    localparam int NUM_ARCH = 2 ** ARCH_W;

    logic [PHYS_W-1:0] spec_rat_r        [NUM_ARCH];
    logic [PHYS_W-1:0] commit_rat_r      [NUM_ARCH];
    logic [PHYS_W-1:0] commit_rat_next_s [NUM_ARCH];
    logic [PHYS_W-1:0] free_list_r       [FL_DEPTH];

    logic [PTR_W-1:0]  spec_head_r;
    logic [PTR_W-1:0]  commit_head_r;
    logic [PTR_W-1:0]  tail_r;

    logic              alloc_1_s;
    logic              alloc_2_s;
    logic [1:0]        alloc_n_s;
    logic [PTR_W-1:0]  free_cnt_s;
    logic              in_ready_s;
    logic              fire_s;

    logic [IDX_W-1:0]  head_idx_s;
    logic [IDX_W-1:0]  next_idx_s;
    logic [PHYS_W-1:0] new_prd_1_s;
    logic [PHYS_W-1:0] new_prd_2_s;
    logic [PHYS_W-1:0] old_prd_1_s;
    logic [PHYS_W-1:0] old_prd_2_s;
    logic [PHYS_W-1:0] src_1_1_s;
    logic [PHYS_W-1:0] src_2_1_s;
    logic [PHYS_W-1:0] src_1_2_s;
    logic [PHYS_W-1:0] src_2_2_s;

    logic              cmt_1_s;
    logic              cmt_2_s;
    logic [1:0]        cmt_n_s;
    logic [IDX_W-1:0]  tail_idx_1_s;
    logic [IDX_W-1:0]  tail_idx_2_s;
    logic [PTR_W-1:0]  commit_head_next_s;

    // x0 is hardwired to p0 regardless of the table contents.
    function automatic logic [PHYS_W-1:0] map_src(input logic [ARCH_W-1:0] areg,
                                                  input logic [PHYS_W-1:0] mapped);
        return (areg == {ARCH_W{1'b0}}) ? {PHYS_W{1'b0}} : mapped;
    endfunction

    function automatic logic [PHYS_W-1:0] bypass(input logic hit,
                                                 input logic [PHYS_W-1:0] fwd,
                                                 input logic [PHYS_W-1:0] base);
        return hit ? fwd : base;
    endfunction

    // Allocation demand, free-list occupancy and the accept handshake.
    always_comb begin
        alloc_1_s  = in_valid_1 & rd_write_1 & (rd_1 != {ARCH_W{1'b0}});
        alloc_2_s  = in_valid_2 & rd_write_2 & (rd_2 != {ARCH_W{1'b0}});
        alloc_n_s  = {1'b0, alloc_1_s} + {1'b0, alloc_2_s};
        free_cnt_s = tail_r - spec_head_r;
        in_ready_s = !flush & (!out_valid_1 | out_ready)
                   & (free_cnt_s >= {{(PTR_W-2){1'b0}}, alloc_n_s});
        fire_s     = in_valid_1 & in_ready_s;
    end

    assign in_ready = in_ready_s;

    // Rename lookups; slot 2 sees slot 1's allocation through the bypass.
    always_comb begin
        head_idx_s  = spec_head_r[IDX_W-1:0];
        next_idx_s  = head_idx_s + {{(IDX_W-1){1'b0}}, 1'b1};
        new_prd_1_s = alloc_1_s ? free_list_r[head_idx_s] : {PHYS_W{1'b0}};
        if (alloc_2_s) begin
            new_prd_2_s = alloc_1_s ? free_list_r[next_idx_s] : free_list_r[head_idx_s];
        end else begin
            new_prd_2_s = {PHYS_W{1'b0}};
        end
        old_prd_1_s = alloc_1_s ? spec_rat_r[rd_1] : {PHYS_W{1'b0}};
        if (alloc_2_s) begin
            old_prd_2_s = bypass(alloc_1_s && (rd_1 == rd_2), new_prd_1_s, spec_rat_r[rd_2]);
        end else begin
            old_prd_2_s = {PHYS_W{1'b0}};
        end
        src_1_1_s = map_src(rs1_1, spec_rat_r[rs1_1]);
        src_2_1_s = map_src(rs2_1, spec_rat_r[rs2_1]);
        src_1_2_s = bypass(alloc_1_s && (rs1_2 == rd_1), new_prd_1_s,
                           map_src(rs1_2, spec_rat_r[rs1_2]));
        src_2_2_s = bypass(alloc_1_s && (rs2_2 == rd_1), new_prd_2_s == new_prd_2_s ? new_prd_1_s : new_prd_1_s,
                           map_src(rs2_2, spec_rat_r[rs2_2]));
    end

    // Retirement: committed-RAT image after this cycle's commits (slot 2 is younger).
    always_comb begin
        cmt_1_s            = commit_valid_1 & commit_rd_write_1 & (commit_ard_1 != {ARCH_W{1'b0}});
        cmt_2_s            = commit_valid_2 & commit_rd_write_2 & (commit_ard_2 != {ARCH_W{1'b0}});
        cmt_n_s            = {1'b0, cmt_1_s} + {1'b0, cmt_2_s};
        tail_idx_1_s       = tail_r[IDX_W-1:0];
        tail_idx_2_s       = tail_idx_1_s + {{(IDX_W-1){1'b0}}, cmt_1_s};
        commit_head_next_s = commit_head_r + {{(PTR_W-2){1'b0}}, cmt_n_s};
        for (int i = 0; i < NUM_ARCH; i++) begin
            if (cmt_2_s && (commit_ard_2 == ARCH_W'(i))) begin
                commit_rat_next_s[i] = commit_prd_2;
            end else if (cmt_1_s && (commit_ard_1 == ARCH_W'(i))) begin
                commit_rat_next_s[i] = commit_prd_1;
            end else begin
                commit_rat_next_s[i] = commit_rat_r[i];
            end
        end
    end

    // Free-list pointers; a flush rewinds the speculative head to the retired point.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            spec_head_r   <= {PTR_W{1'b0}};
            commit_head_r <= {PTR_W{1'b0}};
            tail_r        <= PTR_W'(FL_DEPTH);
        end else begin
            commit_head_r <= commit_head_next_s;
            tail_r        <= tail_r + {{(PTR_W-2){1'b0}}, cmt_n_s};
            if (flush) begin
                spec_head_r <= commit_head_next_s;
            end else if (fire_s) begin
                spec_head_r <= spec_head_r + {{(PTR_W-2){1'b0}}, alloc_n_s};
            end
        end
    end

    // Free-list storage: retired old mappings are appended at the tail.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int k = 0; k < FL_DEPTH; k++) begin
                free_list_r[k] <= PHYS_W'(FL_DEPTH + k);
            end
        end else begin
            for (int k = 0; k < FL_DEPTH; k++) begin
                if (cmt_2_s && (tail_idx_2_s == IDX_W'(k))) begin
                    free_list_r[k] <= commit_old_prd_2;
                end else if (cmt_1_s && (tail_idx_1_s == IDX_W'(k))) begin
                    free_list_r[k] <= commit_old_prd_1;
                end
            end
        end
    end

    // Committed RAT.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < NUM_ARCH; i++) begin
                commit_rat_r[i] <= PHYS_W'(i);
            end
        end else begin
            for (int i = 0; i < NUM_ARCH; i++) begin
                commit_rat_r[i] <= commit_rat_next_s[i];
            end
        end
    end

    // Speculative RAT: restored from the committed image on flush.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < NUM_ARCH; i++) begin
                spec_rat_r[i] <= PHYS_W'(i);
            end
        end else begin
            for (int i = 0; i < NUM_ARCH; i++) begin
                if (flush) begin
                    spec_rat_r[i] <= commit_rat_next_s[i];
                end else if (fire_s && alloc_2_s && (rd_2 == ARCH_W'(i))) begin
                    spec_rat_r[i] <= new_prd_2_s;
                end else if (fire_s && alloc_1_s && (rd_1 == ARCH_W'(i))) begin
                    spec_rat_r[i] <= new_prd_1_s;
                end
            end
        end
    end

    // Output group register toward dispatch.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            out_valid_1 <= 1'b0;
            out_valid_2 <= 1'b0;
            prs1_1      <= {PHYS_W{1'b0}};
            prs2_1      <= {PHYS_W{1'b0}};
            prd_1       <= {PHYS_W{1'b0}};
            old_prd_1   <= {PHYS_W{1'b0}};
            prs1_2      <= {PHYS_W{1'b0}};
            prs2_2      <= {PHYS_W{1'b0}};
            prd_2       <= {PHYS_W{1'b0}};
            old_prd_2   <= {PHYS_W{1'b0}};
        end else if (flush) begin
            out_valid_1 <= 1'b0;
            out_valid_2 <= 1'b0;
        end else if (fire_s) begin
            out_valid_1 <= 1'b1;
            out_valid_2 <= in_valid_2;
            prs1_1      <= src_1_1_s;
            prs2_1      <= src_2_1_s;
            prd_1       <= new_prd_1_s;
            old_prd_1   <= old_prd_1_s;
            prs1_2      <= src_1_2_s;
            prs2_2      <= src_2_2_s;
            prd_2       <= new_prd_2_s;
            old_prd_2   <= old_prd_2_s;
        end else if (out_ready) begin
            out_valid_1 <= 1'b0;
            out_valid_2 <= 1'b0;
        end
    end

endmodule

// File: tb/tb_rename_stage.sv
// Bench for rename_stage: directed scenarios followed by random traffic, all checked
// against a queue-based model of the map tables and free-register pool.
module tb_rename_stage;
    logic       clk = 1'b0;
    logic       reset;
    logic       in_valid_1, in_valid_2, rd_write_1, rd_write_2;
    logic [4:0] rs1_1, rs1_2, rs2_1, rs2_2, rd_1, rd_2;
    logic       in_ready, out_ready, out_valid_1, out_valid_2;
    logic [5:0] prs1_1, prs1_2, prs2_1, prs2_2, prd_1, prd_2, old_prd_1, old_prd_2;
    logic       commit_valid_1, commit_valid_2, commit_rd_write_1, commit_rd_write_2;
    logic [4:0] commit_ard_1, commit_ard_2;
    logic [5:0] commit_prd_1, commit_prd_2, commit_old_prd_1, commit_old_prd_2;
    logic       flush;

    rename_stage dut (
        .clk(clk), .reset(reset),
        .in_valid_1(in_valid_1), .in_valid_2(in_valid_2),
        .rd_write_1(rd_write_1), .rd_write_2(rd_write_2),
        .rs1_1(rs1_1), .rs1_2(rs1_2), .rs2_1(rs2_1), .rs2_2(rs2_2),
        .rd_1(rd_1), .rd_2(rd_2),
        .in_ready(in_ready), .out_ready(out_ready),
        .out_valid_1(out_valid_1), .out_valid_2(out_valid_2),
        .prs1_1(prs1_1), .prs1_2(prs1_2), .prs2_1(prs2_1), .prs2_2(prs2_2),
        .prd_1(prd_1), .prd_2(prd_2), .old_prd_1(old_prd_1), .old_prd_2(old_prd_2),
        .commit_valid_1(commit_valid_1), .commit_valid_2(commit_valid_2),
        .commit_rd_write_1(commit_rd_write_1), .commit_rd_write_2(commit_rd_write_2),
        .commit_ard_1(commit_ard_1), .commit_ard_2(commit_ard_2),
        .commit_prd_1(commit_prd_1), .commit_prd_2(commit_prd_2),
        .commit_old_prd_1(commit_old_prd_1), .commit_old_prd_2(commit_old_prd_2),
        .flush(flush)
    );

    always #5 clk = ~clk;

    typedef struct { int ard; int prd; int old; } rob_t;

    int   m_rat  [32];
    int   m_crat [32];
    int   free_q [$];
    rob_t rob_q  [$];
    bit   e_v1, e_v2;
    int   e_p11, e_p21, e_d1, e_o1, e_p12, e_p22, e_d2, e_o2;
    int   checks, errors;
    logic seen_ready;

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 32; i++) begin
            m_rat[i]  = i;
            m_crat[i] = i;
        end
        free_q.delete();
        for (int k = 0; k < 32; k++) free_q.push_back(32 + k);
        rob_q.delete();
        e_v1 = 1'b0;
        e_v2 = 1'b0;
    endtask

    task automatic clear_inputs();
        in_valid_1 = 1'b0; in_valid_2 = 1'b0; rd_write_1 = 1'b0; rd_write_2 = 1'b0;
        rs1_1 = 5'd0; rs1_2 = 5'd0; rs2_1 = 5'd0; rs2_2 = 5'd0; rd_1 = 5'd0; rd_2 = 5'd0;
        commit_valid_1 = 1'b0; commit_valid_2 = 1'b0;
        commit_rd_write_1 = 1'b0; commit_rd_write_2 = 1'b0;
        commit_ard_1 = 5'd0; commit_ard_2 = 5'd0;
        commit_prd_1 = 6'd0; commit_prd_2 = 6'd0;
        commit_old_prd_1 = 6'd0; commit_old_prd_2 = 6'd0;
        flush = 1'b0;
    endtask

    task automatic grp(input logic v1, input logic w1, input logic [4:0] d1,
                       input logic [4:0] s11, input logic [4:0] s21,
                       input logic v2, input logic w2, input logic [4:0] d2,
                       input logic [4:0] s12, input logic [4:0] s22);
        in_valid_1 = v1; rd_write_1 = w1; rd_1 = d1; rs1_1 = s11; rs2_1 = s21;
        in_valid_2 = v2; rd_write_2 = w2; rd_2 = d2; rs1_2 = s12; rs2_2 = s22;
    endtask

    // Retire the oldest n renamed allocations; idle slots carry harmless noise.
    task automatic set_commits(input int n);
        int m;
        logic w;
        m = (n > rob_q.size()) ? rob_q.size() : n;
        if (m >= 1) begin
            commit_valid_1 = 1'b1; commit_rd_write_1 = 1'b1;
            commit_ard_1 = 5'(rob_q[0].ard); commit_prd_1 = 6'(rob_q[0].prd);
            commit_old_prd_1 = 6'(rob_q[0].old);
        end else begin
            w = 1'($urandom_range(0, 1));
            commit_valid_1 = 1'($urandom_range(0, 1)); commit_rd_write_1 = w;
            commit_ard_1 = w ? 5'd0 : 5'($urandom_range(0, 31));
            commit_prd_1 = 6'($urandom_range(0, 63)); commit_old_prd_1 = 6'($urandom_range(0, 63));
        end
        if (m >= 2) begin
            commit_valid_2 = 1'b1; commit_rd_write_2 = 1'b1;
            commit_ard_2 = 5'(rob_q[1].ard); commit_prd_2 = 6'(rob_q[1].prd);
            commit_old_prd_2 = 6'(rob_q[1].old);
        end else begin
            w = 1'($urandom_range(0, 1));
            commit_valid_2 = 1'($urandom_range(0, 1)); commit_rd_write_2 = w;
            commit_ard_2 = w ? 5'd0 : 5'($urandom_range(0, 31));
            commit_prd_2 = 6'($urandom_range(0, 63)); commit_old_prd_2 = 6'($urandom_range(0, 63));
        end
    endtask

    // One clock: check the handshake, advance the model, then check the output group.
    task automatic tick();
        int  an;
        bit  a1, a2, rdy, fire;
        rob_t r;
        #1;
        a1  = in_valid_1 && rd_write_1 && (rd_1 != 5'd0);
        a2  = in_valid_2 && rd_write_2 && (rd_2 != 5'd0);
        an  = int'(a1) + int'(a2);
        rdy = !flush && (!e_v1 || out_ready) && (free_q.size() >= an);
        seen_ready = in_ready;
        chk("in_ready", 8'(in_ready), 8'(rdy));
        fire = in_valid_1 && rdy;
        if (fire) begin
            e_p11 = m_rat[rs1_1]; e_p21 = m_rat[rs2_1];
            e_d1 = 0; e_o1 = 0;
            if (a1) begin
                e_o1 = m_rat[rd_1]; e_d1 = free_q.pop_front(); m_rat[rd_1] = e_d1;
                r.ard = int'(rd_1); r.prd = e_d1; r.old = e_o1; rob_q.push_back(r);
            end
            e_p12 = m_rat[rs1_2]; e_p22 = m_rat[rs2_2];
            e_d2 = 0; e_o2 = 0;
            if (a2) begin
                e_o2 = m_rat[rd_2]; e_d2 = free_q.pop_front(); m_rat[rd_2] = e_d2;
                r.ard = int'(rd_2); r.prd = e_d2; r.old = e_o2; rob_q.push_back(r);
            end
            e_v1 = 1'b1; e_v2 = in_valid_2;
        end
        if (commit_valid_1 && commit_rd_write_1 && commit_ard_1 != 5'd0) begin
            m_crat[commit_ard_1] = int'(commit_prd_1);
            free_q.push_back(int'(commit_old_prd_1));
            rob_q.delete(0);
        end
        if (commit_valid_2 && commit_rd_write_2 && commit_ard_2 != 5'd0) begin
            m_crat[commit_ard_2] = int'(commit_prd_2);
            free_q.push_back(int'(commit_old_prd_2));
            rob_q.delete(0);
        end
        if (flush) begin
            for (int i = rob_q.size() - 1; i >= 0; i--) free_q.push_front(rob_q[i].prd);
            rob_q.delete();
            for (int i = 0; i < 32; i++) m_rat[i] = m_crat[i];
            e_v1 = 1'b0; e_v2 = 1'b0;
        end else if (!fire && out_ready) begin
            e_v1 = 1'b0; e_v2 = 1'b0;
        end
        @(posedge clk);
        #1;
        chk("out_valid_1", 8'(out_valid_1), 8'(e_v1));
        chk("out_valid_2", 8'(out_valid_2), 8'(e_v2));
        if (e_v1) begin
            chk("prs1_1", 8'(prs1_1), 8'(e_p11)); chk("prs2_1", 8'(prs2_1), 8'(e_p21));
            chk("prd_1", 8'(prd_1), 8'(e_d1));    chk("old_prd_1", 8'(old_prd_1), 8'(e_o1));
        end
        if (e_v2) begin
            chk("prs1_2", 8'(prs1_2), 8'(e_p12)); chk("prs2_2", 8'(prs2_2), 8'(e_p22));
            chk("prd_2", 8'(prd_2), 8'(e_d2));    chk("old_prd_2", 8'(old_prd_2), 8'(e_o2));
        end
        clear_inputs();
        @(negedge clk);
    endtask

    task automatic do_reset();
        reset = 1'b0;
        #2;
        model_reset();
        chk("rst_out_valid_1", 8'(out_valid_1), 8'd0);
        chk("rst_out_valid_2", 8'(out_valid_2), 8'd0);
        @(negedge clk);
        reset = 1'b1;
    endtask

    function automatic logic [4:0] pick_reg();
        return ($urandom_range(0, 1) == 0) ? 5'($urandom_range(0, 7)) : 5'($urandom_range(0, 31));
    endfunction

    initial begin
        checks = 0; errors = 0;
        clear_inputs();
        out_ready = 1'b1;
        reset = 1'b0;
        model_reset();
        #3;
        chk("rst_v1", 8'(out_valid_1), 8'd0);   chk("rst_v2", 8'(out_valid_2), 8'd0);
        chk("rst_prs1_1", 8'(prs1_1), 8'd0);    chk("rst_prs2_1", 8'(prs2_1), 8'd0);
        chk("rst_prd_1", 8'(prd_1), 8'd0);      chk("rst_old_1", 8'(old_prd_1), 8'd0);
        chk("rst_prs1_2", 8'(prs1_2), 8'd0);    chk("rst_prs2_2", 8'(prs2_2), 8'd0);
        chk("rst_prd_2", 8'(prd_2), 8'd0);      chk("rst_old_2", 8'(old_prd_2), 8'd0);
        chk("rst_in_ready", 8'(in_ready), 8'd1);
        @(negedge clk);
        reset = 1'b1;

        // Basic pair with intra-group bypass.
        grp(1'b1, 1'b1, 5'd5, 5'd5, 5'd0, 1'b1, 1'b1, 5'd6, 5'd5, 5'd0);
        tick();
        chk("t1_prd_1", 8'(prd_1), 8'd32);   chk("t1_old_1", 8'(old_prd_1), 8'd5);
        chk("t1_prs1_1", 8'(prs1_1), 8'd5);  chk("t1_prd_2", 8'(prd_2), 8'd33);
        chk("t1_prs1_2", 8'(prs1_2), 8'd32); chk("t1_prs2_2", 8'(prs2_2), 8'd0);
        chk("t1_old_2", 8'(old_prd_2), 8'd6);

        // Both slots write the same rd.
        do_reset();
        grp(1'b1, 1'b1, 5'd7, 5'd0, 5'd0, 1'b1, 1'b1, 5'd7, 5'd0, 5'd0);
        tick();
        chk("t2_prd_1", 8'(prd_1), 8'd32); chk("t2_prd_2", 8'(prd_2), 8'd33);
        chk("t2_old_1", 8'(old_prd_1), 8'd7); chk("t2_old_2", 8'(old_prd_2), 8'd32);
        grp(1'b1, 1'b0, 5'd0, 5'd7, 5'd0, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0);
        tick();
        chk("t2_read7", 8'(prs1_1), 8'd33);

        // Exhaust the free list, stall, then recover through a single commit.
        do_reset();
        for (int g = 0; g < 16; g++) begin
            grp(1'b1, 1'b1, (g == 0) ? 5'd5 : 5'($urandom_range(1, 31)), pick_reg(), pick_reg(),
                1'b1, 1'b1, 5'($urandom_range(1, 31)), pick_reg(), pick_reg());
            tick();
        end
        grp(1'b1, 1'b1, 5'd12, 5'd1, 5'd2, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0);
        tick();
        chk("t3_stall", 8'(seen_ready), 8'd0);
        grp(1'b1, 1'b1, 5'd0, 5'd3, 5'd4, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0);
        tick();
        chk("t3_rd0_ok", 8'(seen_ready), 8'd1);
        grp(1'b1, 1'b0, 5'd9, 5'd3, 5'd4, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0);
        tick();
        chk("t3_nowr_ok", 8'(seen_ready), 8'd1);
        set_commits(1);
        tick();
        grp(1'b1, 1'b1, 5'd11, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0);
        tick();
        chk("t3_prd_p5", 8'(prd_1), 8'd5);

        // Back-pressure holds the output group and the rename state.
        do_reset();
        grp(1'b1, 1'b1, 5'd1, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0);
        tick();
        out_ready = 1'b0;
        for (int c = 0; c < 3; c++) begin
            grp(1'b1, 1'b1, 5'd2, 5'd1, 5'd0, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0);
            tick();
            chk("t4_hold_ready", 8'(seen_ready), 8'd0);
            chk("t4_hold_prd", 8'(prd_1), 8'd32);
        end
        out_ready = 1'b1;
        grp(1'b1, 1'b1, 5'd2, 5'd1, 5'd0, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0);
        tick();
        chk("t4_after_prd", 8'(prd_1), 8'd33);
        chk("t4_after_src", 8'(prs1_1), 8'd32);

        // Partial commit then flush.
        do_reset();
        grp(1'b1, 1'b1, 5'd3, 5'd0, 5'd0, 1'b1, 1'b1, 5'd4, 5'd0, 5'd0);
        tick();
        set_commits(1);
        tick();
        flush = 1'b1;
        tick();
        grp(1'b1, 1'b1, 5'd10, 5'd3, 5'd0, 1'b1, 1'b0, 5'd0, 5'd4, 5'd0);
        tick();
        chk("t5_map3", 8'(prs1_1), 8'd32);
        chk("t5_map4", 8'(prs1_2), 8'd4);
        chk("t5_realloc", 8'(prd_1), 8'd33);

        // Flush coinciding with a commit and a valid input group.
        do_reset();
        grp(1'b1, 1'b1, 5'd1, 5'd0, 5'd0, 1'b1, 1'b1, 5'd2, 5'd0, 5'd0); tick();
        grp(1'b1, 1'b1, 5'd3, 5'd0, 5'd0, 1'b1, 1'b1, 5'd4, 5'd0, 5'd0); tick();
        grp(1'b1, 1'b1, 5'd5, 5'd0, 5'd0, 1'b1, 1'b1, 5'd6, 5'd0, 5'd0); tick();
        grp(1'b1, 1'b1, 5'd8, 5'd0, 5'd0, 1'b1, 1'b1, 5'd10, 5'd0, 5'd0); tick();
        grp(1'b1, 1'b1, 5'd9, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0); tick();
        chk("t6_prd40", 8'(prd_1), 8'd40);
        for (int c = 0; c < 4; c++) begin
            set_commits(2);
            tick();
        end
        set_commits(1);
        flush = 1'b1;
        grp(1'b1, 1'b1, 5'd12, 5'd9, 5'd0, 1'b1, 1'b1, 5'd13, 5'd0, 5'd0);
        tick();
        chk("t6_flush_ready", 8'(seen_ready), 8'd0);
        chk("t6_flush_valid", 8'(out_valid_1), 8'd0);
        grp(1'b1, 1'b0, 5'd0, 5'd9, 5'd12, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0);
        tick();
        chk("t6_map9", 8'(prs1_1), 8'd40);
        chk("t6_map12", 8'(prs2_1), 8'd12);

        // Random traffic.
        do_reset();
        for (int n = 0; n < 1500; n++) begin
            logic v1;
            v1 = ($urandom_range(0, 3) != 0);
            grp(v1, ($urandom_range(0, 3) != 0), pick_reg(), pick_reg(), pick_reg(),
                v1 && ($urandom_range(0, 1) == 1), ($urandom_range(0, 3) != 0),
                pick_reg(), pick_reg(), pick_reg());
            out_ready = ($urandom_range(0, 3) != 0);
            set_commits($urandom_range(0, 2));
            flush = ($urandom_range(0, 29) == 0);
            tick();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
